i2c_target_regs: RTL and testbench



---
 rtl/i2c_pkg.sv | 25 ++
 rtl/i2c_target_regs_if.sv | 12 +
 rtl/i2c_line_sync.sv | 49 ++++
 rtl/i2c_target_regs.sv | 203 ++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register port.
package i2c_pkg;

  localparam logic [6:0]  DEV_ADDR_DFLT = 7'h70;
  localparam int unsigned NUM_REGS_DFLT = 12;
  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned BIT_CNT_W     = 3;

  localparam logic I2C_ACK = 1'b0;
  localparam logic I2C_NAK = 1'b1;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    DEVADDR = 4'd1,
    DEVACK  = 4'd2,
    SUBADDR = 4'd3,
    SUBACK  = 4'd4,
    WRDATA  = 4'd5,
    WRACK   = 4'd6,
    RDDATA  = 4'd7,
    RDACK   = 4'd8,
    IGNORE  = 4'd9
  } state_t;

endpackage

// File: rtl/i2c_target_regs_if.sv
// Register-bank side bus of the I2C target: pointer, write data/strobe, read data.
interface i2c_target_regs_if;
  import i2c_pkg::*;

  logic [BYTE_W-1:0] reg_addr;
  logic [BYTE_W-1:0] reg_wdata;
  logic              reg_we;
  logic [BYTE_W-1:0] reg_rdata;

  modport master (output reg_addr, output reg_wdata, output reg_we, input reg_rdata);
  modport slave  (input reg_addr, input reg_wdata, input reg_we, output reg_rdata);
endinterface

// File: rtl/i2c_line_sync.sv
// Pad-line synchroniser with level and edge outputs.
// Define I2C_GLITCH_FILTER_EN to add a 3-sample majority filter (2 clk extra latency).
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise_c,
  output logic fall_c
);

  // Idle-high reset so a freshly reset block sees no bus events.
  logic [1:0] sync_q;
  logic       lvl_d_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], din};
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       filt_q;

  // Majority of the current and two previous synced samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= 2'b11;
      filt_q <= 1'b1;
    end else begin
      hist_q <= {hist_q[0], sync_q[1]};
      filt_q <= (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync_q[1];
`endif

  always_ff @(posedge clk) begin
    if (rst) lvl_d_q <= 1'b1;
    else     lvl_d_q <= lvl;
  end

  assign rise_c = lvl & ~lvl_d_q;
  assign fall_c = ~lvl & lvl_d_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with auto-incrementing 8-bit sub-address pointer onto a register bank.
// Optional I2C_GLITCH_FILTER_EN enables majority filtering of SCL/SDA in i2c_line_sync.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = DEV_ADDR_DFLT,
  parameter int unsigned NUM_REGS = NUM_REGS_DFLT
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_oe,
  output logic busy,
  i2c_target_regs_if.master reg_bus
);

  localparam logic [BYTE_W:0] NUM_REGS_W = (BYTE_W+1)'(NUM_REGS);

  logic scl_lvl, scl_rise_c, scl_fall_c;
  logic sda_lvl, sda_rise_c, sda_fall_c;

  i2c_line_sync u_scl_sync (
    .clk(clk), .rst(rst), .din(scl_in),
    .lvl(scl_lvl), .rise_c(scl_rise_c), .fall_c(scl_fall_c)
  );

  i2c_line_sync u_sda_sync (
    .clk(clk), .rst(rst), .din(sda_in),
    .lvl(sda_lvl), .rise_c(sda_rise_c), .fall_c(sda_fall_c)
  );

  // SCL must be steadily high; an SDA edge coinciding with an SCL edge is data.
  logic start_c, stop_c;
  assign start_c = sda_fall_c & scl_lvl & ~scl_rise_c;
  assign stop_c  = sda_rise_c & scl_lvl & ~scl_rise_c;

  state_t                state_q, state_d;
  logic [BIT_CNT_W-1:0]  cnt_q, cnt_d;
  logic [BYTE_W-1:0]     sh_q, sh_d;
  logic [BYTE_W-1:0]     rd_q, rd_d;
  logic                  rw_q, rw_d;
  logic                  ph_q, ph_d;
  logic                  oe_d, busy_d, we_d;
  logic [BYTE_W-1:0]     addr_d, wdata_d;
  logic [BYTE_W-1:0]     byte_c, rd_byte_c;
  logic                  addr_impl_c;

  assign byte_c      = {sh_q[BYTE_W-2:0], sda_lvl};
  assign addr_impl_c = {1'b0, reg_bus.reg_addr} < NUM_REGS_W;
  assign rd_byte_c   = addr_impl_c ? reg_bus.reg_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      sh_q              <= '0;
      rd_q              <= '0;
      rw_q              <= 1'b0;
      ph_q              <= 1'b0;
      sda_oe            <= 1'b0;
      busy              <= 1'b0;
      reg_bus.reg_addr  <= '0;
      reg_bus.reg_wdata <= '0;
      reg_bus.reg_we    <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      sh_q              <= sh_d;
      rd_q              <= rd_d;
      rw_q              <= rw_d;
      ph_q              <= ph_d;
      sda_oe            <= oe_d;
      busy              <= busy_d;
      reg_bus.reg_addr  <= addr_d;
      reg_bus.reg_wdata <= wdata_d;
      reg_bus.reg_we    <= we_d;
    end
  end

  // ph_q: in ACK states, set once the ACK is driven; in RDACK, set once the host ACKed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    ph_d    = ph_q;
    oe_d    = sda_oe;
    busy_d  = busy;
    addr_d  = reg_bus.reg_addr;
    wdata_d = reg_bus.reg_wdata;
    we_d    = 1'b0;

    if (stop_c) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_c) begin
      state_d = DEVADDR;
      cnt_d   = '0;
      ph_d    = 1'b0;
      oe_d    = 1'b0;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE, IGNORE: oe_d = 1'b0;

        DEVADDR: if (scl_rise_c) begin
          sh_d  = byte_c;
          cnt_d = cnt_q + BIT_CNT_W'(1);
          if (cnt_q == '1) begin
            ph_d = 1'b0;
            if (byte_c[BYTE_W-1:1] == DEV_ADDR) begin
              state_d = DEVACK;
              rw_d    = byte_c[0];
            end else begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end
          end
        end

        DEVACK, SUBACK, WRACK: if (scl_fall_c) begin
          if (!ph_q) begin
            oe_d = 1'b1;
            ph_d = 1'b1;
            if (state_q == WRACK) addr_d = reg_bus.reg_addr + BYTE_W'(1);
          end else begin
            ph_d  = 1'b0;
            cnt_d = '0;
            oe_d  = 1'b0;
            if (state_q == DEVACK && rw_q) begin
              state_d = RDDATA;
              rd_d    = rd_byte_c;
              oe_d    = ~rd_byte_c[BYTE_W-1];
            end else if (state_q == DEVACK) begin
              state_d = SUBADDR;
            end else begin
              state_d = WRDATA;
            end
          end
        end

        SUBADDR, WRDATA: if (scl_rise_c) begin
          sh_d  = byte_c;
          cnt_d = cnt_q + BIT_CNT_W'(1);
          if (cnt_q == '1) begin
            ph_d = 1'b0;
            if (state_q == SUBADDR) begin
              addr_d  = byte_c;
              state_d = SUBACK;
            end else begin
              wdata_d = byte_c;
              we_d    = addr_impl_c;
              state_d = WRACK;
            end
          end
        end

        RDDATA: begin
          if (scl_rise_c) begin
            cnt_d = cnt_q + BIT_CNT_W'(1);
            if (cnt_q == '1) begin
              state_d = RDACK;
              ph_d    = 1'b0;
            end
          end else if (scl_fall_c) begin
            rd_d = {rd_q[BYTE_W-2:0], 1'b0};
            oe_d = ~rd_q[BYTE_W-2];
          end
        end

        RDACK: begin
          if (scl_fall_c && !ph_q) begin
            oe_d   = 1'b0;
            addr_d = reg_bus.reg_addr + BYTE_W'(1);
          end else if (scl_rise_c && !ph_q) begin
            if (sda_lvl == I2C_NAK) begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end else begin
              ph_d = 1'b1;
            end
          end else if (scl_fall_c) begin
            state_d = RDDATA;
            cnt_d   = '0;
            ph_d    = 1'b0;
            rd_d    = rd_byte_c;
            oe_d    = ~rd_byte_c[BYTE_W-1];
          end
        end

        default: begin
          state_d = IDLE;
          oe_d    = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Randomised and directed bench for i2c_target_regs against a transaction-level pointer/bank model.
module tb_i2c_target_regs;
  import i2c_pkg::*;

  localparam int unsigned Q    = 8;
  localparam int unsigned NREG = 12;
  localparam logic [6:0]  DEV  = 7'h70;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_drv = 1'b1;
  logic sda_drv = 1'b1;
  logic scl_in, sda_in, sda_oe, busy;

  int checks = 0;
  int errors = 0;
  int mptr   = 0;
  logic oe_seen = 1'b0;
  logic [15:0] we_q[$];
  logic [15:0] exp_we[$];

  i2c_target_regs_if bus();

  assign scl_in = scl_drv;
  assign sda_in = sda_drv & ~sda_oe;

  i2c_target_regs dut (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
    .sda_oe(sda_oe), .busy(busy), .reg_bus(bus.master)
  );

  always #5 clk = ~clk;

  // Register bank: data is a fixed function of the address, one clk behind.
  always @(posedge clk) bus.reg_rdata <= bus.reg_addr ^ 8'h5A;

  always @(negedge clk) begin
    if (bus.reg_we) we_q.push_back({bus.reg_addr, bus.reg_wdata});
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_bit(input logic b, input logic gl, output logic got);
    wait_clk(Q); sda_drv = b;
    wait_clk(Q); scl_drv = 1'b1;
    if (gl) begin
      wait_clk(Q/2); scl_drv = 1'b0;
      wait_clk(1);   scl_drv = 1'b1;
      wait_clk(Q/2 - 1);
    end else begin
      wait_clk(Q);
    end
    got = sda_in;
    wait_clk(Q); scl_drv = 1'b0;
  endtask

  task automatic i2c_start;
    sda_drv = 1'b1; wait_clk(Q);
    scl_drv = 1'b1; wait_clk(Q);
    sda_drv = 1'b0; wait_clk(Q);
    scl_drv = 1'b0;
  endtask

  task automatic i2c_stop;
    wait_clk(Q); sda_drv = 1'b0;
    wait_clk(Q); scl_drv = 1'b1;
    wait_clk(Q); sda_drv = 1'b1;
    wait_clk(2*Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, input int gl_bit, output logic ack);
    logic g;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], (i == gl_bit), g);
    bus_bit(1'b1, 1'b0, g);
    ack = (g == I2C_ACK);
  endtask

  task automatic rd_byte(input logic nak, output logic [7:0] b);
    logic g;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, 1'b0, g);
      b[i] = g;
    end
    bus_bit(nak, 1'b0, g);
  endtask

  // Transaction-level model: writes land only below NREG; pointer wraps at 256.
  task automatic model_write(input logic [7:0] d);
    if (mptr < NREG) exp_we.push_back({8'(mptr), d});
    mptr = (mptr + 1) % 256;
  endtask

  function automatic logic [7:0] model_read();
    logic [7:0] r;
    r = (mptr < NREG) ? (8'(mptr) ^ 8'h5A) : 8'h00;
    mptr = (mptr + 1) % 256;
    return r;
  endfunction

  task automatic check_writes(input string tag);
    check({tag, "_we_n"}, we_q.size(), exp_we.size());
    for (int i = 0; i < exp_we.size() && i < we_q.size(); i++)
      check({tag, "_we"}, we_q[i], exp_we[i]);
    we_q.delete();
    exp_we.delete();
  endtask

  task automatic write_txn(input logic [7:0] sub, input int n,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                           input string tag);
    logic ack;
    logic [7:0] d;
    i2c_start;
    check({tag, "_busy"}, busy, 1);
    wr_byte({DEV, 1'b0}, -1, ack); check({tag, "_ack_dev"}, ack, 1);
    wr_byte(sub, -1, ack);         check({tag, "_ack_sub"}, ack, 1);
    mptr = sub;
    for (int k = 0; k < n; k++) begin
      d = (k == 0) ? d0 : (k == 1) ? d1 : d2;
      wr_byte(d, -1, ack); check({tag, "_ack_dat"}, ack, 1);
      model_write(d);
    end
    i2c_stop;
    check({tag, "_idle"}, busy, 0);
    check({tag, "_ptr"}, bus.reg_addr, mptr);
    check_writes(tag);
  endtask

  task automatic read_txn(input logic set_sub, input logic [7:0] sub, input int n, input string tag);
    logic ack;
    logic [7:0] b;
    i2c_start;
    if (set_sub) begin
      wr_byte({DEV, 1'b0}, -1, ack); check({tag, "_ack_dev"}, ack, 1);
      wr_byte(sub, -1, ack);         check({tag, "_ack_sub"}, ack, 1);
      mptr = sub;
      i2c_start;
    end
    wr_byte({DEV, 1'b1}, -1, ack); check({tag, "_ack_rd"}, ack, 1);
    for (int k = 0; k < n; k++) begin
      rd_byte(k == n - 1, b);
      check({tag, "_rd"}, b, model_read());
    end
    i2c_stop;
    check({tag, "_idle"}, busy, 0);
    check({tag, "_ptr"}, bus.reg_addr, mptr);
    check_writes(tag);
  endtask

  initial begin
    logic ack, g;
    logic [7:0] sub;

    wait_clk(5);
    rst = 1'b0;
    wait_clk(2);
    check("rst_oe", sda_oe, 0);
    check("rst_addr", bus.reg_addr, 0);
    check("rst_wdata", bus.reg_wdata, 0);
    check("rst_we", bus.reg_we, 0);
    check("rst_busy", busy, 0);

    write_txn(8'h00, 2, 8'hAA, 8'h55, 8'h00, "wr2");
    read_txn(1'b1, 8'h02, 12, "rd12");
    write_txn(8'hFE, 3, 8'h11, 8'h22, 8'h33, "wrap");

    // Foreign address: never ACKed, never driven, never written.
    oe_seen = 1'b0;
    i2c_start;
    wr_byte(8'hE2, -1, ack); check("nodev_ack", ack, 0);
    wr_byte(8'h01, -1, ack);
    i2c_stop;
    check("nodev_oe", oe_seen, 0);
    check_writes("nodev");

    // STOP inside a data byte drops it.
    i2c_start;
    wr_byte({DEV, 1'b0}, -1, ack); check("part_ack_dev", ack, 1);
    wr_byte(8'h05, -1, ack);       check("part_ack_sub", ack, 1);
    mptr = 5;
    for (int i = 0; i < 5; i++) bus_bit(1'b1, 1'b0, g);
    i2c_stop;
    check("part_ptr", bus.reg_addr, mptr);
    check_writes("part");
    write_txn(8'h08, 1, 8'h2B, 8'h00, 8'h00, "after_part");

    // Reset while the target is pulling SDA low in a read byte.
    i2c_start;
    wr_byte({DEV, 1'b0}, -1, ack);
    wr_byte(8'h00, -1, ack);
    i2c_start;
    wr_byte({DEV, 1'b1}, -1, ack); check("rstrd_ack", ack, 1);
    bus_bit(1'b1, 1'b0, g);
    bus_bit(1'b1, 1'b0, g);
    wait_clk(Q); sda_drv = 1'b1;
    wait_clk(Q); scl_drv = 1'b1;
    wait_clk(Q/2);
    check("rstrd_pre_oe", sda_oe, 1);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    check("rstrd_oe", sda_oe, 0);
    check("rstrd_addr", bus.reg_addr, 0);
    check("rstrd_busy", busy, 0);
    wait_clk(Q); scl_drv = 1'b0;
    i2c_stop;
    mptr = 0;
    we_q.delete();
    write_txn(8'h03, 2, 8'h77, 8'h88, 8'h00, "post_rst");

`ifdef I2C_GLITCH_FILTER_EN
    // One-clk SCL dropout inside a data bit must not add a bit.
    i2c_start;
    wr_byte({DEV, 1'b0}, -1, ack);
    wr_byte(8'h06, -1, ack);
    mptr = 6;
    wr_byte(8'hC3, 4, ack); check("glitch_ack", ack, 1);
    model_write(8'hC3);
    i2c_stop;
    check_writes("glitch");
`endif

    for (int t = 0; t < 8; t++) begin
      sub = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom_range(0, 15));
      case ($urandom_range(0, 2))
        0: write_txn(sub, int'($urandom_range(1, 3)), 8'($urandom), 8'($urandom), 8'($urandom), "rnd_wr");
        1: read_txn(1'b1, sub, int'($urandom_range(1, 4)), "rnd_rdsub");
        default: read_txn(1'b0, 8'h00, int'($urandom_range(1, 3)), "rnd_rd");
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
